hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller that pairs with the forwarding logic for hazards forwarding cannot cover.
- Detects load-use hazards and inserts one bubble for each.
- Sequences multi-cycle M-extension ops in EX: fixed-latency multiply, and iterative divide via a start/done handshake.
- Freezes the front end while an op is busy and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl_pkg.sv | 13 +
 rtl/hazard_stall_ctrl_load_use.sv | 24 ++
 rtl/hazard_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard/stall sequencing controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_WAIT = 2'b01,
    DIV_WAIT = 2'b10
  } state_e;

  localparam int         MUL_LAT_DEFAULT = 3;
  localparam logic [4:0] REG_X0          = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_load_use.sv
// Combinational load-use hazard detector: a load in EX feeding a source read by ID.
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_ex_rd_i,
  input  logic       id_ex_mem_read_i,
  input  logic       ex_valid_i,
  output logic       luh_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == id_ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == id_ex_rd_i);

  // x0 never carries a real dependency, so a load targeting it cannot stall.
  assign luh_o = id_ex_mem_read_i && ex_valid_i && (id_ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle MUL/DIV holds in EX,
// flush handling and a saturating stall-cycle performance counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_valid,
  input  logic             ex_is_mul,
  input  logic             ex_is_div,
  input  logic             div_done,
  input  logic             ex_flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             div_start,
  output logic             div_abort,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic luh;
  logic freeze;
  logic lu_stall;
  logic start_int;
  logic abort_int;
  logic pc_write_int;

  load_use_detect u_load_use (
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_uses_rs1_i   (id_uses_rs1),
    .id_uses_rs2_i   (id_uses_rs2),
    .id_ex_rd_i      (id_ex_rd),
    .id_ex_mem_read_i(id_ex_mem_read),
    .ex_valid_i      (ex_valid),
    .luh_o           (luh)
  );

  // Load-use is only honoured in IDLE without a launch: a frozen ID/EX already holds the consumer.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    freeze    = 1'b0;
    lu_stall  = 1'b0;
    start_int = 1'b0;
    abort_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && ex_is_mul && !ex_flush) begin
          freeze    = 1'b1;
          state_d   = MUL_WAIT;
          mul_cnt_d = CW'(MUL_LAT - 2);
        end else if (ex_valid && ex_is_div && !ex_flush) begin
          freeze    = 1'b1;
          start_int = 1'b1;
          state_d   = DIV_WAIT;
        end else begin
          lu_stall = luh;
        end
      end
      MUL_WAIT: begin
        if (ex_flush) begin
          state_d = IDLE;
        end else if (mul_cnt_q != '0) begin
          freeze    = 1'b1;
          mul_cnt_d = mul_cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      DIV_WAIT: begin
        if (ex_flush) begin
          abort_int = 1'b1;
          state_d   = IDLE;
        end else if (div_done) begin
          state_d = IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_write_int = !(freeze || lu_stall);

  assign stall_d = (!pc_write_int && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;

  // Outputs are forced to their idle values while reset is held, independent of inputs.
  assign pc_write      = !rst || pc_write_int;
  assign if_id_write   = !rst || pc_write_int;
  assign id_ex_write   = !rst || !freeze;
  assign id_ex_bubble  = rst && lu_stall;
  assign ex_mem_bubble = rst && freeze;
  assign div_start     = rst && start_int;
  assign div_abort     = rst && abort_int;
  assign busy          = rst && (state_q != IDLE);
  assign stall_cycles  = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; a second instance with CNT_W=4
// shares the stimulus to exercise counter saturation.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ex_mem_read;
  logic       ex_valid, ex_is_mul, ex_is_div, div_done, ex_flush;

  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic        div_start, div_abort, busy;
  logic [31:0] stall_cycles;

  logic       s_pc_write, s_if_id_write, s_id_ex_write, s_id_ex_bubble, s_ex_mem_bubble;
  logic       s_div_start, s_div_abort, s_busy;
  logic [3:0] s_stall_cycles;

  int checks    = 0;
  int failures  = 0;
  int expStall  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_valid(ex_valid),
    .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div), .div_done(div_done), .ex_flush(ex_flush),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .div_start(div_start),
    .div_abort(div_abort), .busy(busy), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(4)) dutS (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_valid(ex_valid),
    .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div), .div_done(div_done), .ex_flush(ex_flush),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
    .id_ex_bubble(s_id_ex_bubble), .ex_mem_bubble(s_ex_mem_bubble), .div_start(s_div_start),
    .div_abort(s_div_abort), .busy(s_busy), .stall_cycles(s_stall_cycles)
  );

  task automatic clearInputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
    ex_valid = 1'b0; ex_is_mul = 1'b0; ex_is_div = 1'b0; div_done = 1'b0; ex_flush = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    #1 rst = 1'b0;
    ex_valid = 1'b1; ex_is_div = 1'b1; id_ex_mem_read = 1'b1;
    id_ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #2;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL rst_pc_write got=%0b exp=1", pc_write); end
    checks++; if (if_id_write !== 1'b1) begin failures++; $display("[TB] FAIL rst_if_id_write got=%0b exp=1", if_id_write); end
    checks++; if (id_ex_write !== 1'b1) begin failures++; $display("[TB] FAIL rst_id_ex_write got=%0b exp=1", id_ex_write); end
    checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL rst_id_ex_bubble got=%0b exp=0", id_ex_bubble); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL rst_ex_mem_bubble got=%0b exp=0", ex_mem_bubble); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("[TB] FAIL rst_div_start got=%0b exp=0", div_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL rst_stall got=%0d exp=0", stall_cycles); end
    checks++; if (s_stall_cycles !== 4'd0) begin failures++; $display("[TB] FAIL rst_sat_stall got=%0d exp=0", s_stall_cycles); end
    repeat (2) @(posedge clk);
    #1;
    clearInputs();
    rst = 1'b1;
    expStall = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_release_busy got=%0b exp=0", busy); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_pc_write got=%0b exp=1", pc_write); end
  endtask

  task automatic test_load_use();
    nextCycle();
    ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL lu_pc_write got=%0b exp=0", pc_write); end
    checks++; if (if_id_write !== 1'b0) begin failures++; $display("[TB] FAIL lu_if_id_write got=%0b exp=0", if_id_write); end
    checks++; if (id_ex_bubble !== 1'b1) begin failures++; $display("[TB] FAIL lu_id_ex_bubble got=%0b exp=1", id_ex_bubble); end
    checks++; if (id_ex_write !== 1'b1) begin failures++; $display("[TB] FAIL lu_id_ex_write got=%0b exp=1", id_ex_write); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL lu_ex_mem_bubble got=%0b exp=0", ex_mem_bubble); end
    expStall++;
    nextCycle();
    id_ex_rd = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL lu_x0_pc_write got=%0b exp=1", pc_write); end
    checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL lu_x0_bubble got=%0b exp=0", id_ex_bubble); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL lu_stall got=%0d exp=%0d", stall_cycles, expStall); end
    nextCycle();
    id_ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL lu_unused_pc_write got=%0b exp=1", pc_write); end
    nextCycle();
    id_uses_rs1 = 1'b1;
    @(negedge clk);
    checks++; if (id_ex_bubble !== 1'b1) begin failures++; $display("[TB] FAIL lu_rs1_bubble got=%0b exp=1", id_ex_bubble); end
    expStall++;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL lu_stall_end got=%0d exp=%0d", stall_cycles, expStall); end
  endtask

  task automatic test_mul();
    nextCycle();
    ex_valid = 1'b1; ex_is_mul = 1'b1;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL mul_t0_pc_write got=%0b exp=0", pc_write); end
    checks++; if (id_ex_write !== 1'b0) begin failures++; $display("[TB] FAIL mul_t0_id_ex_write got=%0b exp=0", id_ex_write); end
    checks++; if (ex_mem_bubble !== 1'b1) begin failures++; $display("[TB] FAIL mul_t0_ex_mem_bubble got=%0b exp=1", ex_mem_bubble); end
    checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("[TB] FAIL mul_t0_lu_masked got=%0b exp=0", id_ex_bubble); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mul_t0_busy got=%0b exp=0", busy); end
    expStall++;
    nextCycle();
    id_ex_mem_read = 1'b0; id_uses_rs1 = 1'b0;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL mul_t1_pc_write got=%0b exp=0", pc_write); end
    checks++; if (ex_mem_bubble !== 1'b1) begin failures++; $display("[TB] FAIL mul_t1_ex_mem_bubble got=%0b exp=1", ex_mem_bubble); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mul_t1_busy got=%0b exp=1", busy); end
    expStall++;
    nextCycle();
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL mul_t2_pc_write got=%0b exp=1", pc_write); end
    checks++; if (id_ex_write !== 1'b1) begin failures++; $display("[TB] FAIL mul_t2_id_ex_write got=%0b exp=1", id_ex_write); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL mul_t2_ex_mem_bubble got=%0b exp=0", ex_mem_bubble); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mul_t2_busy got=%0b exp=1", busy); end
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mul_t3_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL mul_stall got=%0d exp=%0d", stall_cycles, expStall); end
  endtask

  task automatic test_div();
    nextCycle();
    ex_valid = 1'b1; ex_is_div = 1'b1;
    @(negedge clk);
    checks++; if (div_start !== 1'b1) begin failures++; $display("[TB] FAIL div_start_pulse got=%0b exp=1", div_start); end
    checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL div_t0_pc_write got=%0b exp=0", pc_write); end
    checks++; if (ex_mem_bubble !== 1'b1) begin failures++; $display("[TB] FAIL div_t0_ex_mem_bubble got=%0b exp=1", ex_mem_bubble); end
    expStall++;
    for (int i = 1; i < 17; i++) begin
      nextCycle();
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin failures++; $display("[TB] FAIL div_start_hold[%0d] got=%0b exp=0", i, div_start); end
      checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL div_freeze[%0d] got=%0b exp=0", i, pc_write); end
      expStall++;
    end
    nextCycle();
    div_done = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL div_done_release got=%0b exp=1", pc_write); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL div_done_bubble got=%0b exp=0", ex_mem_bubble); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL div_done_busy got=%0b exp=1", busy); end
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL div_end_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL div_stall got=%0d exp=%0d", stall_cycles, expStall); end
  endtask

  task automatic test_flush();
    nextCycle();
    ex_valid = 1'b1; ex_is_div = 1'b1;
    @(negedge clk);
    expStall++;
    for (int i = 1; i < 5; i++) begin
      nextCycle();
      @(negedge clk);
      expStall++;
    end
    nextCycle();
    ex_flush = 1'b1;
    @(negedge clk);
    checks++; if (div_abort !== 1'b1) begin failures++; $display("[TB] FAIL flush_div_abort got=%0b exp=1", div_abort); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL flush_release got=%0b exp=1", pc_write); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL flush_bubble got=%0b exp=0", ex_mem_bubble); end
    nextCycle();
    clearInputs();
    div_done = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got=%0b exp=0", busy); end
    checks++; if (div_abort !== 1'b0) begin failures++; $display("[TB] FAIL flush_abort_single got=%0b exp=0", div_abort); end
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL stray_done_pc_write got=%0b exp=1", pc_write); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL flush_stall got=%0d exp=%0d", stall_cycles, expStall); end
    nextCycle();
    clearInputs();
    ex_valid = 1'b1; ex_is_mul = 1'b1; ex_flush = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stray_done_busy got=%0b exp=0", busy); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL idle_flush_launch got=%0b exp=0", ex_mem_bubble); end
    nextCycle();
    ex_flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_flush_busy got=%0b exp=0", busy); end
    checks++; if (ex_mem_bubble !== 1'b1) begin failures++; $display("[TB] FAIL mul_flush_launch got=%0b exp=1", ex_mem_bubble); end
    expStall++;
    nextCycle();
    ex_flush = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL mul_flush_release got=%0b exp=1", pc_write); end
    checks++; if (div_abort !== 1'b0) begin failures++; $display("[TB] FAIL mul_flush_no_abort got=%0b exp=0", div_abort); end
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mul_flush_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL mul_flush_stall got=%0d exp=%0d", stall_cycles, expStall); end
  endtask

  task automatic test_back_to_back();
    nextCycle();
    ex_valid = 1'b1; ex_is_mul = 1'b1;
    @(negedge clk);
    checks++; if (ex_mem_bubble !== 1'b1) begin failures++; $display("[TB] FAIL b2b_mul_launch got=%0b exp=1", ex_mem_bubble); end
    expStall++;
    nextCycle();
    @(negedge clk);
    expStall++;
    nextCycle();
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL b2b_mul_release got=%0b exp=1", pc_write); end
    nextCycle();
    ex_is_mul = 1'b0; ex_is_div = 1'b1;
    @(negedge clk);
    checks++; if (div_start !== 1'b1) begin failures++; $display("[TB] FAIL b2b_div_start got=%0b exp=1", div_start); end
    checks++; if (pc_write !== 1'b0) begin failures++; $display("[TB] FAIL b2b_div_freeze got=%0b exp=0", pc_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_div_busy0 got=%0b exp=0", busy); end
    expStall++;
    nextCycle();
    @(negedge clk);
    checks++; if (div_start !== 1'b0) begin failures++; $display("[TB] FAIL b2b_div_start_once got=%0b exp=0", div_start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_div_busy1 got=%0b exp=1", busy); end
    expStall++;
    nextCycle();
    div_done = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL b2b_div_release got=%0b exp=1", pc_write); end
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'(expStall)) begin failures++; $display("[TB] FAIL b2b_stall got=%0d exp=%0d", stall_cycles, expStall); end
  endtask

  task automatic test_reset_mid_div();
    nextCycle();
    ex_valid = 1'b1; ex_is_div = 1'b1;
    repeat (3) nextCycle();
    #2 rst = 1'b0;
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_pc_write got=%0b exp=1", pc_write); end
    checks++; if (ex_mem_bubble !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_bubble got=%0b exp=0", ex_mem_bubble); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got=%0b exp=0", busy); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL mid_rst_stall got=%0d exp=0", stall_cycles); end
    checks++; if (s_stall_cycles !== 4'd0) begin failures++; $display("[TB] FAIL mid_rst_sat_stall got=%0d exp=0", s_stall_cycles); end
    nextCycle();
    clearInputs();
    rst = 1'b1;
    expStall = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_release_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_saturation();
    nextCycle();
    ex_valid = 1'b1; ex_is_div = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i != 0) nextCycle();
      @(negedge clk);
      if (i == 10) begin
        checks++; if (s_stall_cycles !== 4'hA) begin failures++; $display("[TB] FAIL sat_mid got=%0h exp=a", s_stall_cycles); end
        checks++; if (stall_cycles !== 32'd10) begin failures++; $display("[TB] FAIL sat_wide_mid got=%0d exp=10", stall_cycles); end
      end
      if (i == 20) begin
        checks++; if (s_stall_cycles !== 4'hF) begin failures++; $display("[TB] FAIL sat_full got=%0h exp=f", s_stall_cycles); end
        checks++; if (stall_cycles !== 32'd20) begin failures++; $display("[TB] FAIL sat_wide_20 got=%0d exp=20", stall_cycles); end
      end
      if (i == 22) begin
        checks++; if (s_stall_cycles !== 4'hF) begin failures++; $display("[TB] FAIL sat_hold got=%0h exp=f", s_stall_cycles); end
      end
    end
    nextCycle();
    div_done = 1'b1;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL sat_end_busy got=%0b exp=0", s_busy); end
    checks++; if (stall_cycles !== 32'd23) begin failures++; $display("[TB] FAIL sat_wide_end got=%0d exp=23", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
